// File: rtl/dispatch_unit.sv
// Dispatch stage: 2-entry decoded-instruction queue that allocates a ROB entry
// and routes the head bundle to the ALU RS, branch RS or load/store queue.
module dispatch_unit #(
    parameter int XLEN      = 32,
    parameter int ROB_TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,

    input  logic                 dec_valid,
    output logic                 dec_ready,
    input  logic                 dec_branch,
    input  logic                 dec_jal,
    input  logic                 dec_alu_src1,
    input  logic                 dec_alu_src2,
    input  logic                 dec_rs1_used,
    input  logic                 dec_rs2_used,
    input  logic                 dec_load,
    input  logic                 dec_store,
    input  logic [1:0]           dec_alu_op,
    input  logic [XLEN-1:0]      dec_pc,
    input  logic [XLEN-1:0]      dec_imm,
    input  logic [4:0]           dec_rs1,
    input  logic [4:0]           dec_rs2,
    input  logic [4:0]           dec_rd,

    output logic                 rob_alloc_valid,
    input  logic                 rob_alloc_ready,
    input  logic [ROB_TAG_W-1:0] rob_tag,

    output logic                 alu_valid,
    input  logic                 alu_ready,
    output logic                 br_valid,
    input  logic                 br_ready,
    output logic                 lsq_valid,
    input  logic                 lsq_ready,

    output logic                 disp_branch,
    output logic                 disp_jal,
    output logic                 disp_alu_src1,
    output logic                 disp_alu_src2,
    output logic                 disp_rs1_used,
    output logic                 disp_rs2_used,
    output logic                 disp_load,
    output logic                 disp_store,
    output logic [1:0]           disp_alu_op,
    output logic [XLEN-1:0]      disp_pc,
    output logic [XLEN-1:0]      disp_imm,
    output logic [4:0]           disp_rs1,
    output logic [4:0]           disp_rs2,
    output logic [4:0]           disp_rd,
    output logic [ROB_TAG_W-1:0] disp_rob_tag,
    output logic [31:0]          disp_count,
    output logic [31:0]          stall_count
);

    typedef struct packed {
        logic            branch;
        logic            jal;
        logic            alu_src1;
        logic            alu_src2;
        logic            rs1_used;
        logic            rs2_used;
        logic            load;
        logic            store;
        logic [1:0]      alu_op;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } entry_t;

    typedef enum logic [1:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_BR,
        CLS_LSQ
    } cls_e;

    entry_t      mem_q [2];
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] disp_count_q, disp_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    entry_t in_entry;
    entry_t head_e;
    cls_e   head_cls;
    logic   hv, is_nop, tgt_ready, fire, pop, enq, stall;

    assign in_entry = '{branch: dec_branch, jal: dec_jal, alu_src1: dec_alu_src1,
                        alu_src2: dec_alu_src2, rs1_used: dec_rs1_used,
                        rs2_used: dec_rs2_used, load: dec_load, store: dec_store,
                        alu_op: dec_alu_op, pc: dec_pc, imm: dec_imm,
                        rs1: dec_rs1, rs2: dec_rs2, rd: dec_rd};

    assign head_e = mem_q[head_q];

    // Memory ops take priority over control flow, which takes priority over NOP.
    always_comb begin
        // NOTE: assign every combinational output a default first so no path leaves it unassigned (no latch).
        head_cls = CLS_ALU;
        if (head_e.load || head_e.store) begin
            head_cls = CLS_LSQ;
        end else if (head_e.branch || head_e.jal) begin
            head_cls = CLS_BR;
        end else if (head_e.alu_op == 2'b00) begin
            head_cls = CLS_NOP;
        end
    end

    always_comb begin
        tgt_ready = 1'b0;
        case (head_cls)
            CLS_ALU: tgt_ready = alu_ready;
            CLS_BR:  tgt_ready = br_ready;
            CLS_LSQ: tgt_ready = lsq_ready;
            default: tgt_ready = 1'b0;
        endcase
    end

    // Each side's valid looks only at the opposite side's ready, so no combinational loop forms.
    assign hv              = (count_q != 2'd0) && !flush;
    assign is_nop          = (head_cls == CLS_NOP);
    assign rob_alloc_valid = hv && !is_nop && tgt_ready;
    assign alu_valid       = hv && (head_cls == CLS_ALU) && rob_alloc_ready;
    assign br_valid        = hv && (head_cls == CLS_BR)  && rob_alloc_ready;
    assign lsq_valid       = hv && (head_cls == CLS_LSQ) && rob_alloc_ready;
    assign fire            = hv && !is_nop && rob_alloc_ready && tgt_ready;
    assign stall           = hv && !is_nop && !fire;
    assign pop             = fire || (hv && is_nop);
    assign dec_ready       = (count_q < 2'd2);
    assign enq             = dec_valid && dec_ready && !flush;

    always_comb begin
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;
        disp_count_d  = disp_count_q;
        stall_count_d = stall_count_q;
        if (flush) begin
            count_d = 2'd0;
            head_d  = 1'b0;
            tail_d  = 1'b0;
        end else begin
            if (enq) tail_d = ~tail_q;
            if (pop) head_d = ~head_q;
            case ({enq, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
        if (fire)  disp_count_d  = disp_count_q + 32'd1;
        if (stall) stall_count_d = stall_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two queue entries are reset too, so disp_* read 0 straight out of reset.
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            head_q        <= 1'b0;
            tail_q        <= 1'b0;
            count_q       <= 2'd0;
            disp_count_q  <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            if (enq) begin
                mem_q[tail_q] <= in_entry;
            end
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            disp_count_q  <= disp_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign disp_branch   = head_e.branch;
    assign disp_jal      = head_e.jal;
    assign disp_alu_src1 = head_e.alu_src1;
    assign disp_alu_src2 = head_e.alu_src2;
    assign disp_rs1_used = head_e.rs1_used;
    assign disp_rs2_used = head_e.rs2_used;
    assign disp_load     = head_e.load;
    assign disp_store    = head_e.store;
    assign disp_alu_op   = head_e.alu_op;
    assign disp_pc       = head_e.pc;
    assign disp_imm      = head_e.imm;
    assign disp_rs1      = head_e.rs1;
    assign disp_rs2      = head_e.rs2;
    assign disp_rd       = head_e.rd;
    assign disp_rob_tag  = rob_tag;
    assign disp_count    = disp_count_q;
    assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_dispatch_unit.sv
// Bench for dispatch_unit: directed bundles feed a scoreboard; a negedge monitor
// checks every ROB/target handshake, plus directed checks of counters and readies.
module tb_dispatch_unit;

    localparam int TGT_ALU = 1;
    localparam int TGT_BR  = 2;
    localparam int TGT_LSQ = 3;

    localparam int K_NOP   = 0;
    localparam int K_RTYPE = 1;
    localparam int K_ADDI  = 2;
    localparam int K_BR    = 3;
    localparam int K_JAL   = 4;
    localparam int K_LOAD  = 5;
    localparam int K_STORE = 6;

    logic        clk, rst_n, flush;
    logic        dec_valid, dec_ready;
    logic        dec_branch, dec_jal, dec_alu_src1, dec_alu_src2;
    logic        dec_rs1_used, dec_rs2_used, dec_load, dec_store;
    logic [1:0]  dec_alu_op;
    logic [31:0] dec_pc, dec_imm;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        rob_alloc_valid, rob_alloc_ready;
    logic [3:0]  rob_tag;
    logic        alu_valid, alu_ready, br_valid, br_ready, lsq_valid, lsq_ready;
    logic        disp_branch, disp_jal, disp_alu_src1, disp_alu_src2;
    logic        disp_rs1_used, disp_rs2_used, disp_load, disp_store;
    logic [1:0]  disp_alu_op;
    logic [31:0] disp_pc, disp_imm;
    logic [4:0]  disp_rs1, disp_rs2, disp_rd;
    logic [3:0]  disp_rob_tag;
    logic [31:0] disp_count, stall_count;

    typedef struct {
        int          tgt;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    logic [31:0] exp_disp  = 0;
    logic [31:0] exp_stall = 0;

    dispatch_unit #(.XLEN(32), .ROB_TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_branch(dec_branch), .dec_jal(dec_jal),
        .dec_alu_src1(dec_alu_src1), .dec_alu_src2(dec_alu_src2),
        .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
        .dec_load(dec_load), .dec_store(dec_store), .dec_alu_op(dec_alu_op),
        .dec_pc(dec_pc), .dec_imm(dec_imm),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .rob_alloc_valid(rob_alloc_valid), .rob_alloc_ready(rob_alloc_ready),
        .rob_tag(rob_tag),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .br_valid(br_valid), .br_ready(br_ready),
        .lsq_valid(lsq_valid), .lsq_ready(lsq_ready),
        .disp_branch(disp_branch), .disp_jal(disp_jal),
        .disp_alu_src1(disp_alu_src1), .disp_alu_src2(disp_alu_src2),
        .disp_rs1_used(disp_rs1_used), .disp_rs2_used(disp_rs2_used),
        .disp_load(disp_load), .disp_store(disp_store), .disp_alu_op(disp_alu_op),
        .disp_pc(disp_pc), .disp_imm(disp_imm),
        .disp_rs1(disp_rs1), .disp_rs2(disp_rs2), .disp_rd(disp_rd),
        .disp_rob_tag(disp_rob_tag),
        .disp_count(disp_count), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Drive one bundle onto the decoder port; the caller advances the clock.
    task automatic set_bundle(input int kind, input logic [31:0] pc, input bit track);
        exp_t e;
        dec_branch = 0; dec_jal = 0; dec_alu_src1 = 0; dec_alu_src2 = 0;
        dec_rs1_used = 0; dec_rs2_used = 0; dec_load = 0; dec_store = 0;
        dec_alu_op = 2'b00;
        e.tgt = 0;
        case (kind)
            K_RTYPE: begin dec_alu_op = 2'b10; dec_rs1_used = 1; dec_rs2_used = 1; e.tgt = TGT_ALU; end
            K_ADDI:  begin dec_alu_op = 2'b11; dec_alu_src2 = 1; dec_rs1_used = 1; e.tgt = TGT_ALU; end
            K_BR:    begin dec_alu_op = 2'b01; dec_branch = 1; dec_rs1_used = 1; dec_rs2_used = 1; e.tgt = TGT_BR; end
            K_JAL:   begin dec_alu_op = 2'b11; dec_jal = 1; dec_alu_src1 = 1; e.tgt = TGT_BR; end
            K_LOAD:  begin dec_alu_op = 2'b11; dec_load = 1; dec_alu_src2 = 1; dec_rs1_used = 1; e.tgt = TGT_LSQ; end
            K_STORE: begin dec_alu_op = 2'b11; dec_store = 1; dec_alu_src2 = 1; dec_rs1_used = 1; dec_rs2_used = 1; e.tgt = TGT_LSQ; end
            default: begin end
        endcase
        dec_pc    = pc;
        dec_imm   = pc ^ 32'h0000_abcd;
        dec_rd    = pc[6:2];
        dec_rs1   = 5'd1;
        dec_rs2   = 5'd2;
        dec_valid = 1'b1;
        e.pc  = dec_pc;
        e.imm = dec_imm;
        e.rd  = dec_rd;
        if (track && e.tgt != 0) sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every ROB handshake is a dispatch and must match the oldest expected bundle.
    always @(negedge clk) begin
        if (rst_n && rob_alloc_valid && rob_alloc_ready) begin
            exp_t e;
            int   got_tgt;
            got_tgt = 0;
            if (alu_valid) got_tgt = TGT_ALU;
            if (br_valid)  got_tgt = TGT_BR;
            if (lsq_valid) got_tgt = TGT_LSQ;
            check("one_target_valid", 32'(alu_valid + br_valid + lsq_valid), 32'd1);
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: dispatch of pc 0x%0h with no expected bundle", disp_pc);
            end else begin
                e = sb_q.pop_front();
                check("sb_target", 32'(got_tgt), 32'(e.tgt));
                check("sb_pc", disp_pc, e.pc);
                check("sb_imm", disp_imm, e.imm);
                check("sb_rd", 32'(disp_rd), 32'(e.rd));
                check("sb_rob_tag", 32'(disp_rob_tag), 32'(rob_tag));
            end
        end
    end

    initial begin
        rst_n = 0; flush = 0; dec_valid = 0;
        rob_alloc_ready = 1; rob_tag = 4'd0;
        alu_ready = 1; br_ready = 1; lsq_ready = 1;
        set_bundle(K_NOP, 32'h0, 1'b0);
        dec_valid = 0;

        // Reset state
        #12;
        check("rst_dec_ready", 32'(dec_ready), 32'd1);
        check("rst_valids", 32'({rob_alloc_valid, alu_valid, br_valid, lsq_valid}), 32'd0);
        check("rst_disp_pc", disp_pc, 32'd0);
        check("rst_disp_count", disp_count, 32'd0);
        check("rst_stall_count", stall_count, 32'd0);
        @(negedge clk);
        rst_n = 1;
        tick();

        // Single R-type: presented the cycle after acceptance, tag 3
        rob_tag = 4'd3;
        set_bundle(K_RTYPE, 32'h100, 1'b1);
        tick();
        dec_valid = 0;
        @(negedge clk);
        check("alu_latency_valid", 32'(alu_valid), 32'd1);
        check("alu_latency_rob", 32'(rob_alloc_valid), 32'd1);
        check("alu_disp_pc", disp_pc, 32'h100);
        check("alu_rob_tag", 32'(disp_rob_tag), 32'd3);
        tick();
        exp_disp += 1;
        check("alu_disp_count", disp_count, exp_disp);

        // Routing stream: lsq, br, br, alu at one per cycle
        rob_tag = 4'd5;
        set_bundle(K_LOAD, 32'h200, 1'b1); tick();
        set_bundle(K_BR,   32'h204, 1'b1); tick();
        set_bundle(K_JAL,  32'h208, 1'b1); tick();
        set_bundle(K_ADDI, 32'h20c, 1'b1); tick();
        dec_valid = 0;
        repeat (2) tick();
        exp_disp += 4;
        check("route_disp_count", disp_count, exp_disp);
        check("route_stall_count", stall_count, exp_stall);

        // NOP is dropped, store follows one cycle later
        set_bundle(K_NOP, 32'h280, 1'b1); tick();
        set_bundle(K_STORE, 32'h284, 1'b1);
        @(negedge clk);
        check("nop_no_valids", 32'({rob_alloc_valid, alu_valid, br_valid, lsq_valid}), 32'd0);
        tick();
        dec_valid = 0;
        @(negedge clk);
        check("nop_store_lsq", 32'(lsq_valid), 32'd1);
        tick();
        exp_disp += 1;
        check("nop_disp_count", disp_count, exp_disp);

        // Backpressure: branch at head blocked for 5 cycles with an ALU bundle behind it
        br_ready = 0;
        set_bundle(K_BR, 32'h300, 1'b1); tick();
        set_bundle(K_RTYPE, 32'h304, 1'b1); tick();
        dec_valid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_rob_valid_low", 32'(rob_alloc_valid), 32'd0);
            check("bp_dec_ready_low", 32'(dec_ready), 32'd0);
            tick();
        end
        exp_stall += 5;
        check("bp_stall_count", stall_count, exp_stall);
        check("bp_dec_ready", 32'(dec_ready), 32'd0);
        br_ready = 1;
        @(negedge clk);
        check("bp_release_fire", 32'(rob_alloc_valid & br_valid), 32'd1);
        check("bp_release_pc", disp_pc, 32'h300);
        repeat (3) tick();
        exp_disp += 2;
        check("bp_disp_count", disp_count, exp_disp);
        check("bp_stall_after", stall_count, exp_stall);

        // ROB full: ALU head held until allocation is possible
        rob_alloc_ready = 0;
        rob_tag = 4'd9;
        set_bundle(K_ADDI, 32'h400, 1'b1); tick();
        dec_valid = 0;
        @(negedge clk);
        check("robfull_alu_low", 32'(alu_valid), 32'd0);
        tick();
        @(negedge clk);
        check("robfull_held_pc", disp_pc, 32'h400);
        check("robfull_alu_low2", 32'(alu_valid), 32'd0);
        tick();
        rob_alloc_ready = 1;
        @(negedge clk);
        check("robfull_release", 32'(alu_valid & rob_alloc_valid), 32'd1);
        tick();
        exp_disp  += 1;
        exp_stall += 2;
        check("robfull_disp_count", disp_count, exp_disp);
        check("robfull_stall_count", stall_count, exp_stall);

        // Flush with a full queue and a bundle offered the same cycle
        br_ready = 0;
        set_bundle(K_BR, 32'h500, 1'b0); tick();
        set_bundle(K_BR, 32'h504, 1'b0); tick();
        exp_stall += 1;
        set_bundle(K_RTYPE, 32'h508, 1'b0);
        flush = 1;
        br_ready = 1;
        @(negedge clk);
        check("flush_cycle_valids", 32'({rob_alloc_valid, alu_valid, br_valid, lsq_valid}), 32'd0);
        tick();
        flush = 0;
        dec_valid = 0;
        @(negedge clk);
        check("flush_dec_ready", 32'(dec_ready), 32'd1);
        check("flush_valids", 32'({rob_alloc_valid, alu_valid, br_valid, lsq_valid}), 32'd0);
        check("flush_disp_count", disp_count, exp_disp);
        check("flush_stall_count", stall_count, exp_stall);
        repeat (2) tick();
        check("flush_no_replay", disp_count, exp_disp);

        // Asynchronous reset in mid-operation
        alu_ready = 0;
        set_bundle(K_RTYPE, 32'h600, 1'b0); tick();
        dec_valid = 0;
        @(negedge clk);
        check("midrst_head_present", 32'(alu_valid), 32'd1);
        #2 rst_n = 0;
        #1;
        check("midrst_alu_valid", 32'(alu_valid), 32'd0);
        check("midrst_dec_ready", 32'(dec_ready), 32'd1);
        check("midrst_disp_count", disp_count, 32'd0);
        check("midrst_stall_count", stall_count, 32'd0);
        check("midrst_disp_pc", disp_pc, 32'd0);
        @(negedge clk);
        rst_n = 1;
        alu_ready = 1;
        repeat (3) tick();

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dispatch_unit.md
# dispatch_unit

Dispatch stage of the out-of-order core; sits directly after the opcode control decoder and consumes its per-instruction control bundle. Buffers decoded instructions in a 2-entry queue, allocates a ROB entry for each, and routes it to exactly one back-end queue: the ALU reservation station, the branch reservation station, or the load/store queue. Default-decode bundles (NOPs) are consumed and dropped without allocation. Also keeps dispatch and stall statistics counters.

## Interface
- XLEN, 32, width of the PC and immediate fields
- ROB_TAG_W, 4, width of the ROB tag

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  pipeline flush; empties the queue
- dec_valid  in  1  decoder bundle valid
- dec_ready  out  1  unit can accept a bundle
- dec_branch, dec_jal, dec_alu_src1, dec_alu_src2, dec_rs1_used, dec_rs2_used, dec_load, dec_store  in  1 each  control-decoder outputs
- dec_alu_op  in  2  decoder ALU op (00 = NOP/default, 01 = branch, 10 = R-type, 11 = add-style)
- dec_pc, dec_imm  in  XLEN each  instruction PC and immediate
- dec_rs1, dec_rs2, dec_rd  in  5 each  architectural register indices
- rob_alloc_valid  out  1  ROB allocation request
- rob_alloc_ready  in  1  ROB has a free entry
- rob_tag  in  ROB_TAG_W  tag of the entry allocated on a fire
- alu_valid / alu_ready  out / in  1  ALU reservation station handshake
- br_valid / br_ready  out / in  1  branch reservation station handshake
- lsq_valid / lsq_ready  out / in  1  load/store queue handshake
- disp_*  out  same widths as the dec_* fields  payload of the head entry (all control bits, pc, imm, rs1, rs2, rd), shared by all three targets
- disp_rob_tag  out  ROB_TAG_W  equals rob_tag (pass-through)
- disp_count  out  32  number of dispatched non-NOP instructions
- stall_count  out  32  cycles in which a non-NOP head was blocked

## Operation
- Queue: 2-entry circular FIFO (head pointer, tail pointer, 2-bit count). dec_ready = (count < 2). An enqueue happens when dec_valid && dec_ready && !flush.
- Classification of the head entry:
  - LSQ if load or store.
  - Otherwise BR if branch or jal.
  - Otherwise NOP if alu_op == 00.
  - Otherwise ALU.
- Target ready: tgt_ready is the ready of the head entry's class.
- Handshake for a non-NOP head (hv = head valid && !flush):
  - rob_alloc_valid = hv && tgt_ready.
  - Selected target valid = hv && rob_alloc_ready. The other two target valids are 0.
  - fire = hv && rob_alloc_ready && tgt_ready. On fire, pop the head and increment disp_count (wraps modulo 2^32).
- Readies must not depend on valids, because each valid here depends on the other side's ready.
- NOP head: when hv, pop with all valids 0. No allocation and no counter change.
- Stall: a non-NOP head with hv && !fire increments stall_count (wraps).
- Flush: count and pointers go to 0, and any same-cycle enqueue is discarded. All valid outputs are 0 in the flush cycle. Counters are not cleared.
- Simultaneous enqueue and pop with count == 1: count stays 1, and the new entry becomes head next cycle.
- disp_* reflect the head entry whenever count > 0. When the queue is empty they hold the stale entry and have no meaning while all valids are 0.

## Timing
- Reset (asynchronous, rst_n low): count, pointers, and all entries become 0, along with disp_count and stall_count. All valids are 0, dec_ready = 1, and disp_* are 0.
- Latency: a bundle accepted in cycle N is presented on the target and ROB ports from cycle N+1. There is no same-cycle bypass.
- Throughput: one dispatch per cycle when both the ROB and the target are continuously ready.
- Full (count == 2): dec_ready = 0 even if a pop occurs the same cycle.
- Reset mid-operation: entries are lost and the state returns to the reset values immediately.

## Test plan
- Reset then ALU stream: enqueue an R-type bundle (alu_op = 10), pc = 0x100. With all readies = 1, rob_tag = 3 → alu_valid and rob_alloc_valid = 1 in the next cycle, disp_pc = 0x100, disp_rob_tag = 3, disp_count = 1.
- Routing: enqueue a load, a branch, a jal, then an addi → targets, one per cycle, are lsq, br, br, alu. disp_count = 4 and stall_count = 0.
- NOP drop: enqueue an alu_op = 00 bundle followed by a store → the NOP is consumed with no valids asserted, the store reaches lsq_valid one cycle later, and disp_count = 1.
- Backpressure: hold br_ready = 0 for 5 cycles with a branch at the head plus one more bundle queued. Required response:
  - dec_ready = 0 and stall_count = 5.
  - rob_alloc_valid = 0 throughout.
  - On release, the branch dispatches on the first cycle.
- ROB full: rob_alloc_ready = 0 with an ALU head → alu_valid = 0 and the head is held. On rob_alloc_ready = 1, the head fires in that same cycle.
- Flush with count = 2 and dec_valid = 1 → next cycle count = 0, all valids are 0, dec_ready = 1, and the counters are unchanged.
